// File: rtl/cluster_speriph_router_pkg.sv
// Shared constants for the cluster peripheral router: slot map and default geometry.
package cluster_speriph_router_pkg;

  localparam int SPER_EOC_ID         = 0;
  localparam int SPER_TIMER_ID       = 1;
  localparam int SPER_EVENT_U_ID     = 2;
  localparam int NB_SPERIPH_PLUGS_EU = 2;
  localparam int SPER_HWPE_ID        = 4;
  localparam int SPER_ICACHE_CTRL_ID = 7;
  localparam int SPER_DMA_CL_ID      = 8;
  localparam int SPER_DMA_FC_ID      = 9;
  localparam int SPER_EXT_ID         = 10;

  localparam int NB_SPERIPH_DEFAULT  = 11;
  localparam int NB_HWPE_DEFAULT     = 3;
  localparam int SLOT_BITS_DEFAULT   = 4;
  localparam int ID_WIDTH_DEFAULT    = 5;

  // Route entry layout for the default geometry; the router derives its own from its parameters.
  typedef struct packed {
    logic [SLOT_BITS_DEFAULT-1:0] slot;
    logic                         is_err;
    logic [ID_WIDTH_DEFAULT-1:0]  id;
  } speriph_route_t;

endpackage

// File: rtl/cluster_speriph_router_route_fifo.sv
// Synchronous FIFO holding the slot/error/id route of each in-flight request.
module cluster_speriph_router_route_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full is evaluated on the registered count, so a pop never makes room in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cluster_speriph_router.sv
// Cluster peripheral slave-side router: decodes core requests onto slave plugs, keeps an
// in-order route FIFO for responses and answers unmapped/disabled slots with an error.
module cluster_speriph_router
  import cluster_speriph_router_pkg::*;
#(
  parameter int                     NB_SPERIPH      = NB_SPERIPH_DEFAULT,
  parameter int                     NB_HWPE         = NB_HWPE_DEFAULT,
  parameter int                     HWPE_BASE_ID    = SPER_HWPE_ID,
  parameter int                     ADDR_WIDTH      = 32,
  parameter int                     DATA_WIDTH      = 32,
  parameter int                     ID_WIDTH        = ID_WIDTH_DEFAULT,
  parameter int                     SLOT_LSB        = 10,
  parameter int                     SLOT_BITS       = SLOT_BITS_DEFAULT,
  parameter int                     MAX_OUTSTANDING = 4,
  parameter logic [DATA_WIDTH-1:0]  ERR_RDATA       = 32'hBADACCE5
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NB_SPERIPH-1:0]         slot_en_i,
  input  logic                          req_i,
  input  logic [ADDR_WIDTH-1:0]         add_i,
  input  logic                          wen_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  input  logic [DATA_WIDTH/8-1:0]       be_i,
  input  logic [ID_WIDTH-1:0]           id_i,
  output logic                          gnt_o,
  output logic                          r_valid_o,
  output logic [DATA_WIDTH-1:0]         r_rdata_o,
  output logic                          r_opc_o,
  output logic [ID_WIDTH-1:0]           r_id_o,
  output logic [NB_SPERIPH-1:0]         per_req_o,
  output logic [ADDR_WIDTH-1:0]         per_add_o,
  output logic                          per_wen_o,
  output logic [DATA_WIDTH-1:0]         per_wdata_o,
  output logic [DATA_WIDTH/8-1:0]       per_be_o,
  output logic [ID_WIDTH-1:0]           per_id_o,
  input  logic [NB_SPERIPH-1:0]         per_gnt_i,
  input  logic [NB_SPERIPH-1:0]         per_r_valid_i,
  input  logic [DATA_WIDTH-1:0]         per_r_rdata_i [NB_SPERIPH],
  input  logic [NB_SPERIPH-1:0]         per_r_opc_i,
  input  logic [ID_WIDTH-1:0]           per_r_id_i [NB_SPERIPH],
  output logic                          protocol_err_o,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o
);

  if (HWPE_BASE_ID + NB_HWPE > NB_SPERIPH) begin : g_bad_hwpe_map
    $error("HWPE slot range exceeds NB_SPERIPH");
  end

  typedef struct packed {
    logic [SLOT_BITS-1:0] slot;
    logic                 is_err;
    logic [ID_WIDTH-1:0]  id;
  } route_t;

  logic [SLOT_BITS-1:0]    slot;
  logic                    hit, sel_gnt, is_err, full, empty, push, pop;
  logic                    head_rv, head_opc, unexpected;
  logic [DATA_WIDTH-1:0]   head_rdata;
  logic [ID_WIDTH-1:0]     head_id;
  logic [$bits(route_t)-1:0] head_raw;
  route_t                  push_entry, head;
  logic                    protocol_err_q, protocol_err_d;

  assign slot = add_i[SLOT_LSB +: SLOT_BITS];

  // Out-of-range slots never match a plug index, so they fall through to the error target.
  always_comb begin
    hit     = 1'b0;
    sel_gnt = 1'b0;
    for (int k = 0; k < NB_SPERIPH; k++) begin
      if (slot == SLOT_BITS'(k)) begin
        hit     = slot_en_i[k];
        sel_gnt = per_gnt_i[k];
      end
    end
  end

  assign is_err = ~hit;
  assign gnt_o  = ~rst_i & ~full & (is_err ? req_i : sel_gnt);
  assign push   = req_i & gnt_o;

  always_comb begin
    per_req_o = '0;
    for (int k = 0; k < NB_SPERIPH; k++)
      per_req_o[k] = ~rst_i & req_i & ~full & hit & (slot == SLOT_BITS'(k));
  end

  assign per_add_o   = rst_i ? '0 : add_i;
  assign per_wen_o   = ~rst_i & wen_i;
  assign per_wdata_o = rst_i ? '0 : wdata_i;
  assign per_be_o    = rst_i ? '0 : be_i;
  assign per_id_o    = rst_i ? '0 : id_i;

  assign push_entry = '{slot: slot, is_err: is_err, id: id_i};

  cluster_speriph_router_route_fifo #(
    .WIDTH ($bits(route_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) i_route_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_raw),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

  assign head = route_t'(head_raw);

  always_comb begin
    head_rv    = 1'b0;
    head_rdata = '0;
    head_opc   = 1'b0;
    head_id    = '0;
    unexpected = 1'b0;
    for (int k = 0; k < NB_SPERIPH; k++) begin
      if (head.slot == SLOT_BITS'(k)) begin
        head_rv    = per_r_valid_i[k];
        head_rdata = per_r_rdata_i[k];
        head_opc   = per_r_opc_i[k];
        head_id    = per_r_id_i[k];
      end
      if (per_r_valid_i[k] && (empty || head.is_err || head.slot != SLOT_BITS'(k)))
        unexpected = 1'b1;
    end
  end

  always_comb begin
    r_valid_o = 1'b0;
    r_rdata_o = '0;
    r_opc_o   = 1'b0;
    r_id_o    = '0;
    if (!rst_i && !empty) begin
      if (head.is_err) begin
        r_valid_o = 1'b1;
        r_rdata_o = ERR_RDATA;
        r_opc_o   = 1'b1;
        r_id_o    = head.id;
      end else if (head_rv) begin
        r_valid_o = 1'b1;
        r_rdata_o = head_rdata;
        r_opc_o   = head_opc;
        r_id_o    = head_id;
      end
    end
  end

  assign pop = r_valid_o;

  assign protocol_err_d = protocol_err_q | unexpected;
  assign protocol_err_o = protocol_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) protocol_err_q <= 1'b0;
    else       protocol_err_q <= protocol_err_d;
  end

endmodule
